// File: rtl/i2c_master_div.sv
// I2C master: START, address, N data bytes (read or write), STOP; SCL bit = 4*CLK_DIV clocks.
// Latency: busy the cycle after start; 10 + 72*(1+nbytes) clocks per transfer at CLK_DIV=2, plus any stretch.
// Backpressure: slave holds SCL low to freeze the quarter timer; upstream byte flow paced by tx_pop.
module i2c_master_div #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] nbytes,
    input  logic [7:0]       tx_data,
    output logic             tx_pop,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             scl_in,
    input  logic             sda_in
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, WRITE, ACK_W, READ, ACK_R, STOP
    } state_t;

    state_t           state;
    logic [QW-1:0]    qcnt;
    logic [1:0]       phase;
    logic [2:0]       bitc;
    logic [7:0]       shreg;
    logic [LEN_W-1:0] cnt;
    logic             rw_l;
    logic             bit_state;
    logic             stall;
    logic             tick;
    logic             drive_low;

    always_comb begin
        bit_state = state inside {ADDR, ACK_A, WRITE, ACK_W, READ, ACK_R};
        // Hold the timer at the start of the high phase until the bus really goes high.
        stall     = bit_state && (phase == 2'd2) && (qcnt == '0) && !scl_in;
        tick      = !stall && (qcnt == QW'(CLK_DIV - 1));
        drive_low = 1'b0;
        case (state)
            ADDR, WRITE: drive_low = ~shreg[7];
            ACK_R:       drive_low = (cnt > LEN_W'(1));
            default:     drive_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            qcnt     <= '0;
            phase    <= 2'd0;
            bitc     <= 3'd7;
            shreg    <= 8'h00;
            cnt      <= '0;
            rw_l     <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            tx_pop   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            done     <= 1'b0;
            nack     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            tx_pop   <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            if (state != IDLE) begin
                if (tick)
                    qcnt <= '0;
                else if (!stall)
                    qcnt <= qcnt + QW'(1);
            end
            // The byte presented during the pop cycle is the one shifted out.
            if (tx_pop)
                shreg <= tx_data;

            case (state)
                IDLE: begin
                    if (start) begin
                        shreg  <= {addr, rw};
                        rw_l   <= rw;
                        cnt    <= nbytes;
                        nack   <= 1'b0;
                        busy   <= 1'b1;
                        sda_oe <= 1'b1;
                        qcnt   <= '0;
                        phase  <= 2'd0;
                        state  <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd1) begin
                            scl_oe <= 1'b1;
                            phase  <= 2'd0;
                            bitc   <= 3'd7;
                            state  <= ADDR;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd0)
                            scl_oe <= 1'b0;
                        else if (phase == 2'd1)
                            sda_oe <= 1'b0;
                        else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            phase <= 2'd0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd1) begin
                            scl_oe <= 1'b0;
                            sda_oe <= drive_low;
                        end else if (phase == 2'd3) begin
                            scl_oe <= 1'b1;
                            case (state)
                                ADDR, WRITE: begin
                                    shreg <= {shreg[6:0], 1'b0};
                                    bitc  <= bitc - 3'd1;
                                    if (bitc == 3'd0)
                                        state <= (state == ADDR) ? ACK_A : ACK_W;
                                end
                                READ: begin
                                    shreg <= {shreg[6:0], sda_in};
                                    bitc  <= bitc - 3'd1;
                                    if (bitc == 3'd0) begin
                                        rx_data  <= {shreg[6:0], sda_in};
                                        rx_valid <= 1'b1;
                                        state    <= ACK_R;
                                    end
                                end
                                ACK_A: begin
                                    if (sda_in || cnt == '0) begin
                                        nack   <= sda_in;
                                        sda_oe <= 1'b1;
                                        state  <= STOP;
                                    end else if (rw_l) begin
                                        state <= READ;
                                    end else begin
                                        tx_pop <= 1'b1;
                                        state  <= WRITE;
                                    end
                                end
                                ACK_W: begin
                                    cnt <= cnt - LEN_W'(1);
                                    if (sda_in || cnt == LEN_W'(1)) begin
                                        nack   <= sda_in;
                                        sda_oe <= 1'b1;
                                        state  <= STOP;
                                    end else begin
                                        tx_pop <= 1'b1;
                                        state  <= WRITE;
                                    end
                                end
                                ACK_R: begin
                                    cnt <= cnt - LEN_W'(1);
                                    if (cnt == LEN_W'(1)) begin
                                        sda_oe <= 1'b1;
                                        state  <= STOP;
                                    end else begin
                                        state <= READ;
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_div.sv
// Directed bench for i2c_master_div at CLK_DIV=2 with an open-drain bus and scripted slave.
module tb_i2c_master_div;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [4:0] nbytes;
    logic [7:0] tx_data;
    logic       tx_pop, rx_valid, busy, done, nack, scl_oe, sda_oe;
    logic [7:0] rx_data;
    logic       scl_in, sda_in;

    // Bus / slave / monitor state
    logic [127:0] drv;
    logic         slave_low = 1'b0;
    logic         stretch = 1'b0;
    logic         stretch_arm;
    logic         fired = 1'b0;
    int           scnt = 0;
    int           low13 = 0;
    int           idx = 0;
    logic [63:0]  mon_bits = '0;
    int           mon_n = 0;
    logic         scl_p = 1'b1, sda_p = 1'b1, scl_now, sda_now;
    logic [7:0]   tx_tab [0:7] = '{8'hA5, 8'h3C, 8'hC3, 8'h5A, 8'hE7, 8'h00, 8'h00, 8'h00};
    logic [2:0]   tx_ptr = 3'd0;
    logic         pop_d = 1'b0;
    int           pop_cnt = 0;
    logic [7:0]   rx_q [$];

    int compared = 0;
    int mismatched = 0;
    int cyc, p0, r0;

    assign scl_in  = ~scl_oe & ~stretch;
    assign sda_in  = ~sda_oe & ~slave_low;
    assign tx_data = tx_tab[tx_ptr];

    always #5 clk = ~clk;

    i2c_master_div #(.CLK_DIV(2), .LEN_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .rw(rw), .nbytes(nbytes),
        .tx_data(tx_data), .tx_pop(tx_pop), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .done(done), .nack(nack), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_in(scl_in), .sda_in(sda_in)
    );

    // Mid-cycle bus observer, scripted slave, clock stretcher and byte source.
    always @(negedge clk) begin
        if (pop_d) tx_ptr = tx_ptr + 3'd1;
        pop_d = tx_pop;
        if (tx_pop) pop_cnt++;
        if (rx_valid) rx_q.push_back(rx_data);
        if (!stretch_arm) begin
            fired = 1'b0; scnt = 0; stretch = 1'b0; low13 = 0;
        end else begin
            if (idx == 13 && scl_oe && !fired) begin
                stretch = 1'b1;
                fired   = 1'b1;
            end
            if (stretch && !scl_oe) begin
                scnt++;
                if (scnt == 38) stretch = 1'b0;
            end
            if (idx == 13 && !scl_oe) low13++;
        end
        scl_now = ~scl_oe & ~stretch;
        sda_now = ~sda_oe & ~slave_low;
        if (sda_p && !sda_now && scl_p && scl_now) begin
            idx = 0; mon_n = 0; mon_bits = '0;
        end else if (!scl_p && scl_now) begin
            mon_bits = {mon_bits[62:0], sda_now};
            mon_n++;
        end else if (scl_p && !scl_now) begin
            idx++;
            slave_low = drv[idx];
        end
        scl_p = scl_now;
        sda_p = ~sda_oe & ~slave_low;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_byte(input int base, input logic [7:0] b);
        for (int i = 0; i < 8; i++) drv[base + 1 + i] = ~b[7 - i];
    endtask

    task automatic kick(input logic [6:0] a, input logic r, input logic [4:0] n);
        addr = a; rw = r; nbytes = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (busy === 1'b1 && c < 5000) begin
            c++;
            @(negedge clk);
        end
        chk("done_at_idle", {63'd0, done}, 64'd1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; addr = '0; rw = 1'b0; nbytes = '0;
        drv = '0; stretch_arm = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {48'd0, scl_oe, sda_oe, tx_pop, rx_valid, done, nack, busy, rx_data, 1'b0}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Two-byte write, slave ACKs everything
        drv = '0; drv[9] = 1'b1; drv[18] = 1'b1; drv[27] = 1'b1;
        p0 = pop_cnt;
        kick(7'h50, 1'b0, 5'd2);
        wait_done(cyc);
        chk("wr_cycles", 64'(cyc), 64'd226);
        chk("wr_bit_count", 64'(mon_n), 64'd28);
        chk("wr_bits", mon_bits, {36'd0, 7'h50, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h3C, 1'b0, 1'b0});
        chk("wr_pops", 64'(pop_cnt - p0), 64'd2);
        chk("wr_nack", {63'd0, nack}, 64'd0);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);

        // Three-byte read: master ACK, ACK, NACK
        drv = '0; drv[9] = 1'b1;
        load_byte(9, 8'h12); load_byte(18, 8'h34); load_byte(27, 8'h56);
        r0 = rx_q.size();
        kick(7'h68, 1'b1, 5'd3);
        wait_done(cyc);
        chk("rd_cycles", 64'(cyc), 64'd298);
        chk("rd_bit_count", 64'(mon_n), 64'd37);
        chk("rd_bits", mon_bits, {27'd0, 7'h68, 1'b1, 1'b0, 8'h12, 1'b0, 8'h34, 1'b0, 8'h56, 1'b1, 1'b0});
        chk("rd_valid_count", 64'(rx_q.size() - r0), 64'd3);
        if (rx_q.size() >= r0 + 3) begin
            chk("rd_byte0", {56'd0, rx_q[r0]}, 64'h12);
            chk("rd_byte1", {56'd0, rx_q[r0 + 1]}, 64'h34);
            chk("rd_byte2", {56'd0, rx_q[r0 + 2]}, 64'h56);
        end

        // Address NACK aborts before any pop
        drv = '0;
        p0 = pop_cnt;
        kick(7'h22, 1'b0, 5'd2);
        wait_done(cyc);
        chk("an_nack", {63'd0, nack}, 64'd1);
        chk("an_cycles", 64'(cyc), 64'd82);
        chk("an_bit_count", 64'(mon_n), 64'd10);
        chk("an_bits", mon_bits, {54'd0, 7'h22, 1'b0, 1'b1, 1'b0});
        chk("an_pops", 64'(pop_cnt - p0), 64'd0);

        // Clock stretch of 37 cycles during data bit 4
        drv = '0; drv[9] = 1'b1; drv[18] = 1'b1;
        stretch_arm = 1'b1;
        p0 = pop_cnt;
        kick(7'h3A, 1'b0, 5'd1);
        chk("nack_cleared", {63'd0, nack}, 64'd0);
        wait_done(cyc);
        chk("st_cycles", 64'(cyc), 64'd191);
        chk("st_scl_release", 64'(low13), 64'd41);
        chk("st_bit_count", 64'(mon_n), 64'd19);
        chk("st_bits", mon_bits, {45'd0, 7'h3A, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0});
        chk("st_pops", 64'(pop_cnt - p0), 64'd1);
        stretch_arm = 1'b0;
        @(negedge clk);

        // Address-only probe
        drv = '0; drv[9] = 1'b1;
        p0 = pop_cnt;
        kick(7'h11, 1'b0, 5'd0);
        wait_done(cyc);
        chk("pr_cycles", 64'(cyc), 64'd82);
        chk("pr_bit_count", 64'(mon_n), 64'd10);
        chk("pr_bits", mon_bits, {54'd0, 7'h11, 1'b0, 1'b0, 1'b0});
        chk("pr_pops", 64'(pop_cnt - p0), 64'd0);
        chk("pr_nack", {63'd0, nack}, 64'd0);

        // Reset in the middle of a write data byte
        drv = '0; drv[9] = 1'b1; drv[18] = 1'b1; drv[27] = 1'b1;
        p0 = pop_cnt;
        kick(7'h2B, 1'b0, 5'd2);
        for (int i = 0; i < 500 && pop_cnt == p0; i++) @(negedge clk);
        chk("mid_pop_seen", 64'(pop_cnt - p0), 64'd1);
        repeat (20) @(negedge clk);
        chk("mid_busy_pre", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_reset_release", {61'd0, scl_oe, sda_oe, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Normal write after the reset
        drv = '0; drv[9] = 1'b1; drv[18] = 1'b1;
        p0 = pop_cnt;
        kick(7'h2B, 1'b0, 5'd1);
        wait_done(cyc);
        chk("post_cycles", 64'(cyc), 64'd154);
        chk("post_bit_count", 64'(mon_n), 64'd19);
        chk("post_bits", mon_bits, {45'd0, 7'h2B, 1'b0, 1'b0, 8'hE7, 1'b0, 1'b0});
        chk("post_pops", 64'(pop_cnt - p0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
